// File: rtl/fu_div_iter_if.sv
// fu_div_iter_if.sv
// Shared types and interfaces for the iterative divide FU.
//
//   fu_div_iter_pkg  : fu_input_t / fu_output_t, the operation and result
//                      records exchanged between issue, the FUs and the
//                      writeback arbiter.
//   squash_if        : pipeline flush request. valid is a single bit;
//                      master drives it, slave observes it.
//   fu_div_iter_if   : issue-side handshake and writeback-side result.
//     fuinput_i        operation record (pc, id, prd, rs1val, rs2val)
//     div_op_i         bit0 = unsigned, bit1 = remainder
//     fuinput_i_valid  issue offers an operation
//     fuinput_i_ready  unit can accept an operation this cycle
//     fuoutput_o       result record (pc, id, prd, rdval)
//     fuoutput_o_valid one-cycle result pulse
//   Modport master is the issue/writeback side; slave is the FU.

package fu_div_iter_pkg;

  localparam int FU_XLEN  = 64;
  localparam int FU_ID_W  = 8;
  localparam int FU_PRD_W = 7;

  typedef struct packed {
    logic [FU_XLEN-1:0]  pc;
    logic [FU_ID_W-1:0]  id;
    logic [FU_PRD_W-1:0] prd;
    logic [FU_XLEN-1:0]  rs1val;
    logic [FU_XLEN-1:0]  rs2val;
  } fu_input_t;

  typedef struct packed {
    logic [FU_XLEN-1:0]  pc;
    logic [FU_ID_W-1:0]  id;
    logic [FU_PRD_W-1:0] prd;
    logic [FU_XLEN-1:0]  rdval;
  } fu_output_t;

endpackage

interface squash_if;
  logic valid;

  modport master (output valid);
  modport slave  (input  valid);
endinterface

interface fu_div_iter_if;
  import fu_div_iter_pkg::*;

  fu_input_t  fuinput_i;
  logic [1:0] div_op_i;
  logic       fuinput_i_valid;
  logic       fuinput_i_ready;
  fu_output_t fuoutput_o;
  logic       fuoutput_o_valid;

  modport master (
    output fuinput_i, div_op_i, fuinput_i_valid,
    input  fuinput_i_ready, fuoutput_o, fuoutput_o_valid
  );

  modport slave (
    input  fuinput_i, div_op_i, fuinput_i_valid,
    output fuinput_i_ready, fuoutput_o, fuoutput_o_valid
  );
endinterface

// File: rtl/fu_div_iter.sv
// fu_div_iter.sv
// Iterative RISC-V DIV/DIVU/REM/REMU functional unit using a restoring
// radix-2^BPC datapath. Holds one operation at a time: IDLE accepts,
// ITER retires BPC quotient bits per cycle for XLEN/BPC cycles, DONE
// presents the result for exactly one cycle.
//
// Ports:
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   io_fu      fu_div_iter_if.slave (operation in, result out)
//   squash_io  squash_if.slave, valid flushes the unit
//
// Parameters:
//   XLEN  operand/result width, must equal fu_div_iter_pkg::FU_XLEN
//   BPC   quotient bits per cycle (1, 2 or 4), XLEN % BPC == 0
//
// Build option:
//   FU_DIV_EARLY_OUT_EN  divide-by-zero and signed-overflow operations
//                        bypass ITER and go straight from IDLE to DONE.

module fu_div_iter
  import fu_div_iter_pkg::*;
#(
  parameter int XLEN = FU_XLEN,
  parameter int BPC  = 1
) (
  input  logic   clk,
  input  logic   rstn,
  fu_div_iter_if.slave io_fu,
  squash_if.slave      squash_io
);

  localparam int N     = XLEN / BPC;
  localparam int CNT_W = $clog2(N);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [XLEN-1:0]     r_quo;
  logic [XLEN-1:0]     r_rem;
  logic [XLEN-1:0]     r_divisor;
  logic [XLEN-1:0]     r_rs1;
  logic                r_remSel;
  logic                r_negQ;
  logic                r_negR;
  logic                r_divZero;
  logic                r_ovf;
  logic [FU_XLEN-1:0]  r_pc;
  logic [FU_ID_W-1:0]  r_id;
  logic [FU_PRD_W-1:0] r_prd;
  fu_output_t          r_out;

  logic [XLEN-1:0] w_rs1;
  logic [XLEN-1:0] w_rs2;
  logic            w_unsigned;
  logic            w_rs1Neg;
  logic            w_rs2Neg;
  logic            w_divZero;
  logic            w_ovf;
  logic [XLEN-1:0] w_rs1Mag;
  logic [XLEN-1:0] w_rs2Mag;
  logic [XLEN:0]   w_trial;
  logic [XLEN:0]   w_diff;
  logic [XLEN-1:0] w_quoNext;
  logic [XLEN-1:0] w_remNext;
  logic [XLEN-1:0] w_qSigned;
  logic [XLEN-1:0] w_rSigned;
  logic [XLEN-1:0] w_result;

  // Special-case result: divide-by-zero gives all ones / the dividend,
  // signed overflow gives the dividend (which is the most negative value) / 0.
  function automatic logic [XLEN-1:0] specialResult(input logic divZero,
                                                    input logic remSel,
                                                    input logic [XLEN-1:0] rs1);
    if (divZero) return remSel ? rs1 : '1;
    return remSel ? '0 : rs1;
  endfunction

  assign w_rs1      = io_fu.fuinput_i.rs1val;
  assign w_rs2      = io_fu.fuinput_i.rs2val;
  assign w_unsigned = io_fu.div_op_i[0];
  assign w_rs1Neg   = !w_unsigned && w_rs1[XLEN-1];
  assign w_rs2Neg   = !w_unsigned && w_rs2[XLEN-1];
  assign w_rs1Mag   = w_rs1Neg ? -w_rs1 : w_rs1;
  assign w_rs2Mag   = w_rs2Neg ? -w_rs2 : w_rs2;
  assign w_divZero  = (w_rs2 == '0);
  assign w_ovf      = !w_unsigned && (w_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (w_rs2 == '1);

  assign io_fu.fuinput_i_ready  = (r_state == IDLE);
  assign io_fu.fuoutput_o_valid = (r_state == DONE) && !squash_io.valid;
  assign io_fu.fuoutput_o       = r_out;

  // One ITER cycle: BPC restoring steps. The dividend shifts out of the
  // top of r_quo while quotient bits shift into its bottom, so after N
  // cycles r_quo holds the full magnitude quotient.
  always_comb begin
    w_quoNext = r_quo;
    w_remNext = r_rem;
    w_trial   = '0;
    w_diff    = '0;
    for (int s = 0; s < BPC; s++) begin
      w_trial   = {w_remNext, w_quoNext[XLEN-1]};
      w_quoNext = {w_quoNext[XLEN-2:0], 1'b0};
      w_diff    = w_trial - {1'b0, r_divisor};
      if (!w_diff[XLEN]) begin
        w_remNext    = w_diff[XLEN-1:0];
        w_quoNext[0] = 1'b1;
      end else begin
        w_remNext = w_trial[XLEN-1:0];
      end
    end
  end

  // Final result on the last ITER cycle: sign fixup of the magnitudes,
  // quotient/remainder select, then the special-case override.
  always_comb begin
    w_qSigned = r_negQ ? -w_quoNext : w_quoNext;
    w_rSigned = r_negR ? -w_remNext : w_remNext;
    if (r_divZero || r_ovf) begin
      w_result = specialResult(r_divZero, r_remSel, r_rs1);
    end else begin
      w_result = r_remSel ? w_rSigned : w_qSigned;
    end
  end

  // Control FSM and datapath registers. Squash wins over everything but
  // reset and leaves the datapath untouched; the op in flight is simply
  // abandoned. The output record only changes on entry to DONE, so it
  // holds its last value between pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_rs1     <= '0;
      r_remSel  <= 1'b0;
      r_negQ    <= 1'b0;
      r_negR    <= 1'b0;
      r_divZero <= 1'b0;
      r_ovf     <= 1'b0;
      r_pc      <= '0;
      r_id      <= '0;
      r_prd     <= '0;
      r_out     <= '0;
    end else if (squash_io.valid) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (io_fu.fuinput_i_valid) begin
            r_pc      <= io_fu.fuinput_i.pc;
            r_id      <= io_fu.fuinput_i.id;
            r_prd     <= io_fu.fuinput_i.prd;
            r_remSel  <= io_fu.div_op_i[1];
            r_negQ    <= w_rs1Neg ^ w_rs2Neg;
            r_negR    <= w_rs1Neg;
            r_divZero <= w_divZero;
            r_ovf     <= w_ovf;
            r_rs1     <= w_rs1;
            r_quo     <= w_rs1Mag;
            r_divisor <= w_rs2Mag;
            r_rem     <= '0;
            r_cnt     <= '0;
`ifdef FU_DIV_EARLY_OUT_EN
            if (w_divZero || w_ovf) begin
              r_state     <= DONE;
              r_out.pc    <= io_fu.fuinput_i.pc;
              r_out.id    <= io_fu.fuinput_i.id;
              r_out.prd   <= io_fu.fuinput_i.prd;
              r_out.rdval <= specialResult(w_divZero, io_fu.div_op_i[1], w_rs1);
            end else begin
              r_state <= ITER;
            end
`else
            r_state <= ITER;
`endif
          end
        end
        ITER: begin
          r_quo <= w_quoNext;
          r_rem <= w_remNext;
          if (r_cnt == CNT_W'(N - 1)) begin
            r_state     <= DONE;
            r_out.pc    <= r_pc;
            r_out.id    <= r_id;
            r_out.prd   <= r_prd;
            r_out.rdval <= w_result;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fu_div_iter.sv
// tb_fu_div_iter.sv
// Self-checking bench for fu_div_iter. Issued operations push their
// expected record and due cycle into a scoreboard queue; a separate
// monitor pops and compares on every result pulse. Expected values come
// from a plain-arithmetic model of RISC-V division semantics.
// Honours FU_DIV_EARLY_OUT_EN for the special-case latency.

module tb_fu_div_iter;
  import fu_div_iter_pkg::*;

  localparam int XLEN = 64;
  localparam int BPC  = 1;
  localparam int N    = XLEN / BPC;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef struct {
    logic [63:0] pc;
    logic [7:0]  id;
    logic [6:0]  prd;
    logic [63:0] rdval;
    int          dueCycle;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  int   cycle = 0;
  int   checks = 0;
  int   errors = 0;
  int   idTag = 0;
  exp_t scoreQ[$];

  fu_div_iter_if io_fu ();
  squash_if      sq ();

  fu_div_iter #(.XLEN(XLEN), .BPC(BPC)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .io_fu     (io_fu),
    .squash_io (sq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%h required=0x%h", name, act, req);
    end
  endtask

  function automatic logic isSpecial(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    return (b == 64'd0) || (!op[0] && a == MINV && b == '1);
  endfunction

  // RISC-V M-extension division rules in plain arithmetic.
  function automatic logic [63:0] refDiv(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sbv;
    logic signed [63:0] sr;
    if (b == 64'd0) return op[1] ? a : '1;
    if (!op[0] && a == MINV && b == '1) return op[1] ? 64'd0 : a;
    if (op[0]) return op[1] ? (a % b) : (a / b);
    sa  = a;
    sbv = b;
    sr  = op[1] ? (sa % sbv) : (sa / sbv);
    return sr;
  endfunction

  function automatic int latencyOf(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
`ifdef FU_DIV_EARLY_OUT_EN
    if (isSpecial(op, a, b)) return 1;
`else
    if (isSpecial(op, a, b)) return N + 1;
`endif
    return N + 1;
  endfunction

  task automatic waitCycle(input int target);
    while (cycle < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one op at a negedge and hold it until accepted (bounded).
  // hold=1 leaves valid high afterwards so the next call is back-to-back.
  task automatic applyStimulus(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                               input bit doPush, input bit hold, output int acc);
    int   waited = 0;
    exp_t e;
    e.pc  = {$urandom, $urandom};
    e.id  = 8'(idTag);
    e.prd = 7'($urandom_range(0, 127));
    idTag++;
    acc = -1;
    @(negedge clk);
    io_fu.fuinput_i.pc     = e.pc;
    io_fu.fuinput_i.id     = e.id;
    io_fu.fuinput_i.prd    = e.prd;
    io_fu.fuinput_i.rs1val = a;
    io_fu.fuinput_i.rs2val = b;
    io_fu.div_op_i         = op;
    io_fu.fuinput_i_valid  = 1'b1;
    while (!io_fu.fuinput_i_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!io_fu.fuinput_i_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout actual=ready_low required=ready_high");
      io_fu.fuinput_i_valid = 1'b0;
      return;
    end
    acc        = cycle;
    e.rdval    = refDiv(op, a, b);
    e.dueCycle = acc + latencyOf(op, a, b);
    if (doPush) scoreQ.push_back(e);
    @(posedge clk);
    #1;
    if (!hold) io_fu.fuinput_i_valid = 1'b0;
  endtask

  // Monitor: every result pulse must match the oldest expected record.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (io_fu.fuoutput_o_valid === 1'b1) begin
        if (scoreQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_valid actual=pulse required=none rdval=0x%h", io_fu.fuoutput_o.rdval);
        end else begin
          e = scoreQ.pop_front();
          checkOutput("rdval",   io_fu.fuoutput_o.rdval, e.rdval);
          checkOutput("id",      64'(io_fu.fuoutput_o.id), 64'(e.id));
          checkOutput("prd",     64'(io_fu.fuoutput_o.prd), 64'(e.prd));
          checkOutput("pc",      io_fu.fuoutput_o.pc, e.pc);
          checkOutput("latency", 64'(cycle), 64'(e.dueCycle));
        end
      end
    end
  end

  initial begin
    #800000;
    errors++;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int acc, acc2, anyReady, waited;
    logic [1:0]  op;
    logic [63:0] a, b;

    rstn                  = 1'b0;
    sq.valid              = 1'b0;
    io_fu.fuinput_i       = '0;
    io_fu.div_op_i        = 2'b00;
    io_fu.fuinput_i_valid = 1'b0;
    #23;
    checkOutput("reset_ready", 64'(io_fu.fuinput_i_ready), 64'd1);
    checkOutput("reset_valid", 64'(io_fu.fuoutput_o_valid), 64'd0);
    checkOutput("reset_rdval", io_fu.fuoutput_o.rdval, 64'd0);
    checkOutput("reset_pc",    io_fu.fuoutput_o.pc, 64'd0);
    checkOutput("reset_id",    64'(io_fu.fuoutput_o.id), 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    $display("[TB] DIV 100/7 with busy window");
    applyStimulus(OP_DIV, 64'd100, 64'd7, 1'b1, 1'b0, acc);
    checkOutput("ref_100_7", refDiv(OP_DIV, 64'd100, 64'd7), 64'd14);
    anyReady = 0;
    for (int k = 1; k <= N + 1; k++) begin
      @(negedge clk);
      if (io_fu.fuinput_i_ready) anyReady++;
    end
    checkOutput("busy_ready", 64'(anyReady), 64'd0);
    @(negedge clk);
    checkOutput("ready_after_done", 64'(io_fu.fuinput_i_ready), 64'd1);

    $display("[TB] signed/unsigned and special cases");
    applyStimulus(OP_REM,  -64'sd7, 64'd2, 1'b1, 1'b0, acc);
    applyStimulus(OP_DIV,  -64'sd7, 64'd2, 1'b1, 1'b0, acc);
    applyStimulus(OP_REMU, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, acc);
    applyStimulus(OP_DIVU, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, acc);
    applyStimulus(OP_DIVU, 64'd5, 64'd0, 1'b1, 1'b0, acc);
    applyStimulus(OP_DIV,  -64'sd5, 64'd0, 1'b1, 1'b0, acc);
    applyStimulus(OP_REM,  -64'sd5, 64'd0, 1'b1, 1'b0, acc);
    applyStimulus(OP_DIV,  MINV, '1, 1'b1, 1'b0, acc);
    applyStimulus(OP_REM,  MINV, '1, 1'b1, 1'b0, acc);
    applyStimulus(OP_DIV,  64'd1000, 64'd10, 1'b1, 1'b0, acc);

    $display("[TB] squash mid-iteration");
    applyStimulus(OP_DIV, 64'd12345, 64'd17, 1'b0, 1'b0, acc);
    waitCycle(acc + 30);
    sq.valid = 1'b1;
    @(posedge clk);
    #1;
    sq.valid = 1'b0;
    checkOutput("ready_after_squash", 64'(io_fu.fuinput_i_ready), 64'd1);
    applyStimulus(OP_DIV, 64'd9, 64'd3, 1'b1, 1'b0, acc);

    $display("[TB] squash coincident with accept");
    waitCycle(acc + N + 3);
    @(negedge clk);
    io_fu.fuinput_i.rs1val = 64'd50;
    io_fu.fuinput_i.rs2val = 64'd5;
    io_fu.div_op_i         = OP_DIVU;
    io_fu.fuinput_i_valid  = 1'b1;
    sq.valid               = 1'b1;
    checkOutput("ready_during_squash", 64'(io_fu.fuinput_i_ready), 64'd1);
    @(negedge clk);
    io_fu.fuinput_i_valid = 1'b0;
    sq.valid              = 1'b0;
    checkOutput("squash_blocks_accept", 64'(io_fu.fuinput_i_ready), 64'd1);

    $display("[TB] squash during result cycle");
    applyStimulus(OP_DIVU, 64'd77, 64'd7, 1'b0, 1'b0, acc);
    waitCycle(acc + N + 1);
    sq.valid = 1'b1;
    @(posedge clk);
    #1;
    sq.valid = 1'b0;
    checkOutput("ready_after_done_squash", 64'(io_fu.fuinput_i_ready), 64'd1);

    $display("[TB] back-to-back issue");
    applyStimulus(OP_DIVU, 64'd1000, 64'd10, 1'b1, 1'b1, acc);
    applyStimulus(OP_REMU, 64'd1003, 64'd10, 1'b1, 1'b0, acc2);
    checkOutput("b2b_gap", 64'(acc2 - acc), 64'(N + 2));

    $display("[TB] reset mid-iteration");
    applyStimulus(OP_DIV, 64'd999, 64'd3, 1'b0, 1'b0, acc);
    waitCycle(acc + 10);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("rst_ready", 64'(io_fu.fuinput_i_ready), 64'd1);
    checkOutput("rst_valid", 64'(io_fu.fuoutput_o_valid), 64'd0);
    checkOutput("rst_rdval", io_fu.fuoutput_o.rdval, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    waitCycle(acc + N + 8);

    $display("[TB] randomized operations");
    for (int i = 0; i < 150; i++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0: begin a = {$urandom, $urandom}; b = 64'd0; end
        1: begin a = MINV; b = '1; end
        2: begin a = 64'($signed($urandom_range(0, 2000)) - 1000);
                 b = 64'($signed($urandom_range(1, 40)) - 20); end
        3: begin a = {$urandom, $urandom};
                 b = 64'($urandom_range(1, 1000));
                 if ($urandom_range(0, 1) == 1) b = -b; end
        default: begin a = {$urandom, $urandom};
                       b = {$urandom, $urandom} >> $urandom_range(0, 63); end
      endcase
      applyStimulus(op, a, b, 1'b1, 1'($urandom_range(0, 1)), acc);
    end
    io_fu.fuinput_i_valid = 1'b0;

    waited = 0;
    while (scoreQ.size() != 0 && waited < 4 * N) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("drain", 64'(scoreQ.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
